// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and load/store.
// One outstanding access with fixed latency; data wins unless fetch has waited MAX_STREAK grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_dqm,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_dqm,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  localparam logic [2:0] LAT_C    = 3'(MEM_LAT);
  localparam logic [3:0] STREAK_C = 4'(MAX_STREAK);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  streak_q, streak_d;
  logic        owner_d_q, owner_d_d;
  logic        owner_we_q, owner_we_d;
  logic        resp_s, window_s, d_win_s, f_win_s;

  // Arbitration window and winner; gated by rst so nothing is granted during reset.
  always_comb begin
    resp_s   = (state_q == ST_WAIT) && (cnt_q == LAT_C);
    window_s = rst && ((state_q == ST_IDLE) || resp_s);
    d_win_s  = window_s && d_req && !(if_req && (streak_q == STREAK_C));
    f_win_s  = window_s && if_req && !d_win_s;
  end

  // Memory port mux, grants and response steering.
  always_comb begin
    if_gnt    = f_win_s;
    d_gnt     = d_win_s;
    mem_en    = f_win_s | d_win_s;
    mem_we    = d_win_s & d_we;
    mem_wdata = d_win_s ? d_wdata : '0;
    mem_dqm   = d_win_s ? d_dqm : 2'b00;
    if (d_win_s) begin
      mem_addr = d_addr;
    end else if (f_win_s) begin
      mem_addr = if_addr;
    end else begin
      mem_addr = '0;
    end
    if_rvalid = resp_s & ~owner_d_q;
    d_rvalid  = resp_s & owner_d_q;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = (d_rvalid && !owner_we_q) ? mem_rdata : '0;
    busy      = (state_q == ST_WAIT);
  end

  // Next-state: a grant (re)starts the latency count, otherwise count toward the response.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    owner_d_d  = owner_d_q;
    owner_we_d = owner_we_q;
    if (f_win_s || d_win_s) begin
      state_d    = ST_WAIT;
      cnt_d      = 3'd1;
      owner_d_d  = d_win_s;
      owner_we_d = d_win_s & d_we;
      if (d_win_s && if_req) begin
        streak_d = (streak_q == STREAK_C) ? streak_q : streak_q + 4'd1;
      end else begin
        streak_d = 4'd0;
      end
    end else if (resp_s) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_q + 3'd1;
    end else begin
      cnt_d = 3'd0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      streak_q   <= 4'd0;
      owner_d_q  <= 1'b0;
      owner_we_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      owner_d_q  <= owner_d_d;
      owner_we_q <= owner_we_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, checked each cycle
// against a timeline model (grant time, owner, streak) kept in the bench.
module tb_mem_port_arbiter;
  localparam int LAT  = 3;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_dqm, mem_dqm;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .MAX_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_dqm(d_dqm),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_dqm(mem_dqm), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int last_gnt = -100;
  int streak_m = 0;
  bit last_d, last_we;
  bit g_f, g_d;
  bit auto_mode, hold_if, hold_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    int age;
    bit on, outst, resp, win, ed, ef;
    logic [31:0] e_addr;
    @(negedge clk);
    on    = (rst === 1'b1);
    age   = cyc - last_gnt;
    outst = on && (age >= 1) && (age <= LAT);
    resp  = on && (age == LAT);
    win   = on && (!outst || resp);
    ed    = win && d_req && !(if_req && (streak_m == MAXS));
    ef    = win && if_req && !ed;
    e_addr = ed ? d_addr : (ef ? if_addr : 32'h0);
    chk("if_gnt", {31'd0, if_gnt}, {31'd0, ef});
    chk("d_gnt", {31'd0, d_gnt}, {31'd0, ed});
    chk("mem_en", {31'd0, mem_en}, {31'd0, ef | ed});
    chk("mem_we", {31'd0, mem_we}, {31'd0, ed & d_we});
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, ed ? d_wdata : 32'h0);
    chk("mem_dqm", {30'd0, mem_dqm}, ed ? {30'd0, d_dqm} : 32'h0);
    chk("busy", {31'd0, busy}, {31'd0, outst});
    chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, resp & !last_d});
    chk("if_rdata", if_rdata, (resp && !last_d) ? mem_rdata : 32'h0);
    chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, resp & last_d});
    chk("d_rdata", d_rdata, (resp && last_d && !last_we) ? mem_rdata : 32'h0);
    if (!on) begin
      last_gnt = -100;
      streak_m = 0;
    end else if (ed || ef) begin
      last_gnt = cyc;
      last_d   = ed;
      last_we  = ed && d_we;
      if (ed && if_req) streak_m = (streak_m < MAXS) ? streak_m + 1 : streak_m;
      else streak_m = 0;
    end
    g_f = ef;
    g_d = ed;
    @(posedge clk);
    #1;
    cyc++;
    mem_rdata = $urandom();
    if (auto_mode) begin
      if (g_f || !if_req) begin
        if_req  = ($urandom_range(0, 99) < 60);
        if_addr = $urandom();
      end else if ($urandom_range(0, 99) < 5) begin
        if_req = 1'b0;
      end
      if (g_d || !d_req) begin
        d_req   = ($urandom_range(0, 99) < 60);
        d_we    = $urandom_range(0, 1);
        d_addr  = $urandom();
        d_wdata = $urandom();
        d_dqm   = 2'($urandom_range(0, 3));
      end else if ($urandom_range(0, 99) < 5) begin
        d_req = 1'b0;
      end
    end else begin
      if (g_f && !hold_if) if_req = 1'b0;
      if (g_d && !hold_d) d_req = 1'b0;
    end
  endtask

  task automatic drain();
    if_req = 1'b0;
    d_req  = 1'b0;
    repeat (LAT + 1) step();
  endtask

  initial begin
    logic [9:0] seq;
    int ng;
    rst = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_dqm = 2'b00;
    mem_rdata = 32'h0;
    auto_mode = 1'b0; hold_if = 1'b0; hold_d = 1'b0;

    // reset state, with a request pending that must not be granted
    if_req = 1'b1; if_addr = 32'h44;
    step(); step();
    rst = 1'b1;
    if_req = 1'b0;

    // single fetch
    if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
    step();
    repeat (LAT + 1) step();

    // simultaneous load and fetch: data first, fetch in response cycle
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    if_req = 1'b1; if_addr = 32'h20;
    repeat (2 * LAT + 3) step();

    // bounded data streak with both requesters held
    drain();
    hold_if = 1'b1; hold_d = 1'b1;
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    seq = 10'd0; ng = 0;
    for (int i = 0; i < 100 && ng < 10; i++) begin
      step();
      if (g_d || g_f) begin
        seq = {seq[8:0], g_d};
        ng++;
      end
    end
    chk("streak_seq", {22'd0, seq}, {22'd0, 10'b1111011110});
    chk("streak_grants", ng, 32'd10);
    hold_if = 1'b0; hold_d = 1'b0;
    drain();

    // store with fetch waiting behind it
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h12345678; d_dqm = 2'b10;
    if_req = 1'b1; if_addr = 32'h30;
    repeat (2 * LAT + 3) step();
    drain();

    // reset mid-transaction
    hold_if = 1'b1;
    if_req = 1'b1; if_addr = 32'h10;
    step();
    rst = 1'b0;
    #1;
    chk("rst_async_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    chk("rst_async_if_gnt", {31'd0, if_gnt}, 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("grant_after_rst", {31'd0, g_f}, 32'd1);
    hold_if = 1'b0;
    if_req = 1'b0;
    repeat (LAT + 1) step();

    // data request withdrawn outside the window
    if_req = 1'b1; if_addr = 32'h50;
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
    step();
    d_req = 1'b0;
    repeat (LAT + 1) step();

    // random traffic with occasional resets
    auto_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b0;
        step();
        rst = 1'b1;
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
